// File: rtl/hdmi_fifo_rd_ctrl_if.sv
// Bundle of the FIFO read port, video timing inputs and pixel outputs used by
// hdmi_fifo_rd_ctrl.
//   fifo_rd_en     read enable toward the frame FIFO
//   fifo_rd_data   FIFO word, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   vs_in, de_in   vertical sync and pixel request from the timing generator
//   pix_data, pix_valid, underflow, underflow_cnt, state_o  pixel-side results
// slave modport: the controller. master modport: the environment driving it.
interface hdmi_fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_empty;
    logic                  vs_in;
    logic                  de_in;
    logic [PIX_WIDTH-1:0]  pix_data;
    logic                  pix_valid;
    logic                  underflow;
    logic [CNT_WIDTH-1:0]  underflow_cnt;
    logic [1:0]            state_o;

    modport slave (
        input  fifo_rd_data, fifo_rd_empty, vs_in, de_in,
        output fifo_rd_en, pix_data, pix_valid, underflow, underflow_cnt, state_o
    );

    modport master (
        output fifo_rd_data, fifo_rd_empty, vs_in, de_in,
        input  fifo_rd_en, pix_data, pix_valid, underflow, underflow_cnt, state_o
    );
endinterface

// File: rtl/hdmi_fifo_rd_ctrl.sv
// Read-side controller for the 32-bit HDMI frame FIFO (pixel clock domain).
// Prefetches up to two FIFO words into a small buffer and unpacks each word
// into two RGB565 pixels (low half first) on data-enable. A rising vertical
// sync realigns to a word boundary; pixel requests with no buffered data emit
// UNDERFLOW_COLOR and are counted.
//   rd_clk  pixel/read clock
//   rd_rst  synchronous active-high reset
//   bus     hdmi_fifo_rd_ctrl_if.slave (FIFO read port, vs/de, pixel outputs)
module hdmi_fifo_rd_ctrl #(
    parameter int                   DATA_WIDTH      = 32,
    parameter int                   PIX_WIDTH       = 16,
    parameter logic [PIX_WIDTH-1:0] UNDERFLOW_COLOR = 16'hF800,
    parameter int                   CNT_WIDTH       = 16
) (
    input logic                 rd_clk,
    input logic                 rd_rst,
    hdmi_fifo_rd_ctrl_if.slave  bus
);

    if (DATA_WIDTH != 2 * PIX_WIDTH) begin : g_bad_width
        $error("hdmi_fifo_rd_ctrl: DATA_WIDTH must equal 2*PIX_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf0;      // head word
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_count;
    logic                  r_inflight;
    logic                  r_half_sel;
    logic                  r_vs_d;
    logic [PIX_WIDTH-1:0]  r_pix_data;
    logic                  r_pix_valid;
    logic                  r_underflow;
    logic [CNT_WIDTH-1:0]  r_underflow_cnt;

    logic                  w_vs_rise;
    logic                  w_rd_en;
    logic                  w_stream;
    logic                  w_consume;
    logic                  w_short;
    logic                  w_half_after;
    logic                  w_half_next;
    logic                  w_pop;
    logic [1:0]            w_base;
    logic [PIX_WIDTH-1:0]  w_head_pix;

    assign w_vs_rise = bus.vs_in & ~r_vs_d;
    assign w_rd_en   = (r_state != ST_IDLE) & ~bus.fifo_rd_empty &
                       (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
    assign w_stream  = (r_state == ST_STREAM);
    assign w_consume = bus.de_in & w_stream & (r_count != 2'd0);
    assign w_short   = bus.de_in & w_stream & (r_count == 2'd0);

    // Pixel consumption is applied first; a vs rise then drops any half-used
    // head word so the next frame starts on a word boundary. At most one pop
    // can result: if consumption already popped, half_sel is back to 0.
    assign w_half_after = w_consume ? ~r_half_sel : r_half_sel;
    assign w_pop        = (w_consume & r_half_sel) | (w_vs_rise & w_half_after);
    assign w_half_next  = w_vs_rise ? 1'b0 : w_half_after;

    // Occupancy after the pop; also the slot an arriving word lands in.
    assign w_base     = r_count - {1'b0, w_pop};
    assign w_head_pix = r_half_sel ? r_buf0[DATA_WIDTH-1:PIX_WIDTH]
                                   : r_buf0[PIX_WIDTH-1:0];

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state         <= ST_IDLE;
            r_buf0          <= '0;
            r_buf1          <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_half_sel      <= 1'b0;
            r_vs_d          <= 1'b0;
            r_pix_data      <= '0;
            r_pix_valid     <= 1'b0;
            r_underflow     <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_vs_d     <= bus.vs_in;
            r_inflight <= w_rd_en;
            r_half_sel <= w_half_next;
            r_count    <= w_base + {1'b0, r_inflight};

            // Shift on pop, then drop the returning word into the first free
            // slot (the later assignment to r_buf0 wins when both apply).
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (r_inflight) begin
                if (w_base == 2'd0) begin
                    r_buf0 <= bus.fifo_rd_data;
                end else begin
                    r_buf1 <= bus.fifo_rd_data;
                end
            end

            r_pix_valid <= bus.de_in;
            if (bus.de_in) begin
                if (w_consume) begin
                    r_pix_data <= w_head_pix;
                end else if (w_short) begin
                    r_pix_data <= UNDERFLOW_COLOR;
                end else begin
                    r_pix_data <= '0;
                end
            end
            r_underflow <= w_short;
            if (w_short && (r_underflow_cnt != '1)) begin
                r_underflow_cnt <= r_underflow_cnt + CNT_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        r_state <= ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if (!w_vs_rise && (r_count == 2'd2) && !r_inflight) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_vs_rise) begin
                        r_state <= ST_PREFILL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.fifo_rd_en    = w_rd_en;
    assign bus.pix_data      = r_pix_data;
    assign bus.pix_valid     = r_pix_valid;
    assign bus.underflow     = r_underflow;
    assign bus.underflow_cnt = r_underflow_cnt;
    assign bus.state_o       = r_state;

endmodule

// File: tb/tb_hdmi_fifo_rd_ctrl.sv
// Bench for hdmi_fifo_rd_ctrl: behavioural standard-mode FIFO, directed
// stimulus with expected pixels queued at request time, and a negedge monitor
// that pops and compares whenever pix_valid is seen.
module tb_hdmi_fifo_rd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdmi_fifo_rd_ctrl_if #(.DATA_WIDTH(32), .PIX_WIDTH(16), .CNT_WIDTH(16)) bus ();

    hdmi_fifo_rd_ctrl #(
        .DATA_WIDTH(32),
        .PIX_WIDTH(16),
        .UNDERFLOW_COLOR(16'hF800),
        .CNT_WIDTH(16)
    ) dut (
        .rd_clk(clk),
        .rd_rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] pix;
        logic        uf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    logic        force_empty = 1'b0;
    logic        mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    task automatic update_empty();
        bus.fifo_rd_empty = force_empty | (fifo_q.size() == 0);
    endtask

    // One clock: sample the read enable mid-cycle, then present FIFO data
    // just after the edge (standard mode, one-cycle latency).
    task automatic step();
        logic en;
        @(negedge clk);
        en = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (en === 1'b1) begin
            if (fifo_q.size() == 0) begin
                chk("read_of_empty_fifo", 32'd1, 32'd0);
            end else begin
                bus.fifo_rd_data = fifo_q.pop_front();
            end
        end
        update_empty();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.de_in = 1'b0;
        bus.vs_in = 1'b0;
        force_empty = 1'b0;
        fifo_q.delete();
        update_empty();
        idle(2);
        rst = 1'b0;
    endtask

    task automatic de_cycle(input logic [15:0] pix, input logic uf, input logic fe);
        exp_t e;
        e.pix = pix;
        e.uf  = uf;
        exp_q.push_back(e);
        bus.de_in = 1'b1;
        force_empty = fe;
        update_empty();
        step();
        bus.de_in = 1'b0;
    endtask

    task automatic vs_pulse();
        bus.vs_in = 1'b1;
        step();
        bus.vs_in = 1'b0;
    endtask

    task automatic wait_stream(input string name);
        for (int i = 0; i < 60; i++) begin
            if (bus.state_o == 2'd2) break;
            step();
        end
        chk(name, 32'(bus.state_o), 32'd2);
    endtask

    task automatic drain(input string name);
        bus.de_in = 1'b0;
        force_empty = 1'b0;
        update_empty();
        idle(3);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pix_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pix_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pix_data", 32'(bus.pix_data), 32'(e.pix));
                    chk("underflow", 32'(bus.underflow), 32'(e.uf));
                end
            end else if (bus.underflow) begin
                chk("underflow_without_valid", 32'(bus.underflow), 32'd0);
            end
            if (bus.fifo_rd_empty) begin
                chk("rd_en_while_empty", 32'(bus.fifo_rd_en), 32'd0);
            end
        end
    end

    initial begin
        bus.de_in = 1'b0;
        bus.vs_in = 1'b0;
        bus.fifo_rd_data = '0;
        update_empty();

        // Idle after reset: data available but no vsync, nothing may happen.
        do_reset();
        mon_en = 1'b1;
        fifo_q.push_back(32'h2222_1111);
        update_empty();
        chk("reset_state", 32'(bus.state_o), 32'd0);
        chk("reset_pix_data", 32'(bus.pix_data), 32'd0);
        chk("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("reset_underflow", 32'(bus.underflow), 32'd0);
        chk("reset_underflow_cnt", 32'(bus.underflow_cnt), 32'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_rd_en", 32'(bus.fifo_rd_en), 32'd0);
            chk("idle_state", 32'(bus.state_o), 32'd0);
            chk("idle_outputs", {bus.pix_data, 14'd0, bus.pix_valid, bus.underflow}, 32'd0);
        end
        // Pixel requests outside STREAM yield black without underflow.
        de_cycle(16'h0000, 1'b0, 1'b0);
        de_cycle(16'h0000, 1'b0, 1'b0);
        drain("drain_idle");
        chk("idle_underflow_cnt", 32'(bus.underflow_cnt), 32'd0);

        // Three words, eight pixel requests: six data pixels, two underflows.
        do_reset();
        fifo_q.push_back(32'h2222_1111);
        fifo_q.push_back(32'h4444_3333);
        fifo_q.push_back(32'h6666_5555);
        update_empty();
        vs_pulse();
        wait_stream("stream_t2");
        de_cycle(16'h1111, 1'b0, 1'b0);
        de_cycle(16'h2222, 1'b0, 1'b0);
        de_cycle(16'h3333, 1'b0, 1'b0);
        de_cycle(16'h4444, 1'b0, 1'b0);
        de_cycle(16'h5555, 1'b0, 1'b0);
        de_cycle(16'h6666, 1'b0, 1'b0);
        de_cycle(16'hF800, 1'b1, 1'b0);
        de_cycle(16'hF800, 1'b1, 1'b0);
        drain("drain_t2");
        chk("underflow_cnt_t2", 32'(bus.underflow_cnt), 32'd2);

        // vsync after three pixels drops the unused high half (4444).
        do_reset();
        fifo_q.push_back(32'h2222_1111);
        fifo_q.push_back(32'h4444_3333);
        fifo_q.push_back(32'h6666_5555);
        fifo_q.push_back(32'h8888_7777);
        update_empty();
        vs_pulse();
        wait_stream("stream_t4a");
        de_cycle(16'h1111, 1'b0, 1'b0);
        de_cycle(16'h2222, 1'b0, 1'b0);
        de_cycle(16'h3333, 1'b0, 1'b0);
        vs_pulse();
        chk("vs_realign_state", 32'(bus.state_o), 32'd1);
        wait_stream("stream_t4b");
        de_cycle(16'h5555, 1'b0, 1'b0);
        de_cycle(16'h6666, 1'b0, 1'b0);
        drain("drain_t4");
        chk("underflow_cnt_t4", 32'(bus.underflow_cnt), 32'd0);

        // FIFO empty on odd request cycles: prefetch starves once, then keeps up.
        do_reset();
        fifo_q.push_back(32'h2222_1111);
        fifo_q.push_back(32'h4444_3333);
        fifo_q.push_back(32'h6666_5555);
        fifo_q.push_back(32'h8888_7777);
        fifo_q.push_back(32'hAAAA_9999);
        fifo_q.push_back(32'hCCCC_BBBB);
        fifo_q.push_back(32'hEEEE_DDDD);
        fifo_q.push_back(32'h1234_FFFF);
        update_empty();
        vs_pulse();
        wait_stream("stream_t5");
        de_cycle(16'h1111, 1'b0, 1'b1);
        de_cycle(16'h2222, 1'b0, 1'b0);
        de_cycle(16'h3333, 1'b0, 1'b1);
        de_cycle(16'h4444, 1'b0, 1'b0);
        de_cycle(16'hF800, 1'b1, 1'b1);
        de_cycle(16'h5555, 1'b0, 1'b0);
        de_cycle(16'h6666, 1'b0, 1'b1);
        de_cycle(16'h7777, 1'b0, 1'b0);
        de_cycle(16'h8888, 1'b0, 1'b1);
        de_cycle(16'h9999, 1'b0, 1'b0);
        de_cycle(16'hAAAA, 1'b0, 1'b1);
        de_cycle(16'hBBBB, 1'b0, 1'b0);
        drain("drain_t5");
        chk("underflow_cnt_t5", 32'(bus.underflow_cnt), 32'd1);

        // Reset while a read is issued: the returning word must be dropped.
        do_reset();
        fifo_q.push_back(32'h2222_1111);
        fifo_q.push_back(32'h4444_3333);
        fifo_q.push_back(32'h6666_5555);
        fifo_q.push_back(32'h8888_7777);
        update_empty();
        vs_pulse();
        wait_stream("stream_t6a");
        de_cycle(16'h1111, 1'b0, 1'b0);
        de_cycle(16'h2222, 1'b0, 1'b0);
        chk("read_in_flight_pre_reset", 32'(bus.fifo_rd_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_reset_state", 32'(bus.state_o), 32'd0);
        chk("mid_reset_outputs", {bus.pix_data, 14'd0, bus.pix_valid, bus.underflow}, 32'd0);
        chk("mid_reset_cnt", 32'(bus.underflow_cnt), 32'd0);
        chk("mid_reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        fifo_q.push_back(32'hAAAA_9999);
        update_empty();
        step();
        vs_pulse();
        wait_stream("stream_t6b");
        de_cycle(16'h7777, 1'b0, 1'b0);
        de_cycle(16'h8888, 1'b0, 1'b0);
        de_cycle(16'h9999, 1'b0, 1'b0);
        drain("drain_t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
